// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 write-only bus driver.
// Contents:
//   lcd_state_t   - write sequencer states (IDLE -> SETUP -> ENABLE -> HOLD -> WAIT)
//   CNT_W         - width of the shared delay counter
//   DEF_*_CYC     - default timing in clk cycles, chosen for a 50 MHz clock
//   LONG_CMD_*    - opcode pattern for clear display / return home
//   is_long_cmd() - picks the long execution wait for a latched request
//   load_val()    - converts a cycle count into a down-counter load value
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ENABLE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_WAIT   = 3'd4
  } lcd_state_t;

  localparam int unsigned CNT_W = 17;

  localparam int unsigned DEF_SETUP_CYC      = 4;
  localparam int unsigned DEF_EN_HIGH_CYC    = 25;
  localparam int unsigned DEF_HOLD_CYC       = 2;
  localparam int unsigned DEF_EXEC_SHORT_CYC = 2500;
  localparam int unsigned DEF_EXEC_LONG_CYC  = 100000;

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  localparam logic [7:0] LONG_CMD_MASK  = 8'hFC;
  localparam logic [7:0] LONG_CMD_VALUE = 8'h00;

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data & LONG_CMD_MASK) == LONG_CMD_VALUE) && (data[1:0] != 2'b00);
  endfunction

  // A phase of N cycles loads N-1; a zero count still gives one cycle.
  function automatic logic [CNT_W-1:0] load_val(input int unsigned cyc);
    int unsigned c;
    c = (cyc == 0) ? 1 : cyc;
    return CNT_W'(c - 1);
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Down-counting phase timer for the LCD write sequencer.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (clears the count)
//   load        - load load_value this cycle (takes priority over counting)
//   load_value  - count to load, i.e. phase length minus one
//   value       - current count
//   zero        - count has reached zero; the owning phase ends this cycle
module lcd_delay_counter
  import lcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] value_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      value_reg <= '0;
    end else if (load) begin
      value_reg <= load_value;
    end else if (value_reg != '0) begin
      // Parks at zero so an idle sequencer never sees a wrapped count.
      value_reg <= value_reg - CNT_W'(1);
    end
  end

  assign value = value_reg;
  assign zero  = (value_reg == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780 write-only bus driver. Accepts one byte per request and sequences
// address setup, enable pulse, hold and the controller's execution wait.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   start           - request strobe, taken only while ready is high
//   rs_in, data_in  - register select (0 command, 1 data) and byte
//   ready           - sequencer idle, a request may be accepted
//   done            - one-cycle pulse when a write and its wait complete
//   overrun         - sticky: start seen while busy (cleared by reset only)
//   lcd_rs, lcd_rw, lcd_en, lcd_data - HD44780 pins (lcd_rw tied low)
module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC      = DEF_SETUP_CYC,
  parameter int unsigned EN_HIGH_CYC    = DEF_EN_HIGH_CYC,
  parameter int unsigned HOLD_CYC       = DEF_HOLD_CYC,
  parameter int unsigned EXEC_SHORT_CYC = DEF_EXEC_SHORT_CYC,
  parameter int unsigned EXEC_LONG_CYC  = DEF_EXEC_LONG_CYC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rs_in,
  input  logic [7:0] data_in,
  output logic       ready,
  output logic       done,
  output logic       overrun,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam logic [CNT_W-1:0] SETUP_LD = load_val(SETUP_CYC);
  localparam logic [CNT_W-1:0] EN_LD    = load_val(EN_HIGH_CYC);
  localparam logic [CNT_W-1:0] HOLD_LD  = load_val(HOLD_CYC);
  localparam logic [CNT_W-1:0] SHORT_LD = load_val(EXEC_SHORT_CYC);
  localparam logic [CNT_W-1:0] LONG_LD  = load_val(EXEC_LONG_CYC);

  lcd_state_t       state_reg, state_next;
  logic             rs_reg;
  logic [7:0]       data_reg;
  logic             en_reg;
  logic             done_reg;
  logic             overrun_reg;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_value;
  logic             cnt_zero;
  // The raw count is only interesting when probing the timer in isolation.
  logic [CNT_W-1:0] cnt_value_unused;

  lcd_delay_counter u_delay (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .value      (cnt_value_unused),
    .zero       (cnt_zero)
  );

  // Every transition into a timed state reloads the counter with that
  // state's length; the state ends on the cycle the count reads zero.
  always_comb begin
    state_next     = state_reg;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next     = ST_SETUP;
          cnt_load       = 1'b1;
          cnt_load_value = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_next     = ST_ENABLE;
          cnt_load       = 1'b1;
          cnt_load_value = EN_LD;
        end
      end
      ST_ENABLE: begin
        if (cnt_zero) begin
          state_next     = ST_HOLD;
          cnt_load       = 1'b1;
          cnt_load_value = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_next     = ST_WAIT;
          cnt_load       = 1'b1;
          cnt_load_value = is_long_cmd(rs_reg, data_reg) ? LONG_LD : SHORT_LD;
        end
      end
      ST_WAIT: begin
        if (cnt_zero) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Pin registers are driven from state_next so they change on the same
  // edge as the state, keeping lcd_en exactly aligned with ENABLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      rs_reg      <= 1'b0;
      data_reg    <= 8'h00;
      en_reg      <= 1'b0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && start) begin
        rs_reg   <= rs_in;
        data_reg <= data_in;
      end
      en_reg   <= (state_next == ST_ENABLE);
      done_reg <= (state_reg == ST_WAIT) && (state_next == ST_IDLE);
      if (start && state_reg != ST_IDLE) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign ready    = (state_reg == ST_IDLE);
  assign done     = done_reg;
  assign overrun  = overrun_reg;
  assign lcd_rs   = rs_reg;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = en_reg;
  assign lcd_data = data_reg;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Directed bench for lcd_bus_driver. Pulse timing uses the default
// setup/enable/hold lengths; the execution waits are shortened so the long
// command case stays short. Latency from the acceptance edge is
// SETUP + EN_HIGH + HOLD + WAIT = 31 + WAIT cycles.
module tb_lcd_bus_driver;

  localparam int unsigned T_SETUP = 4;
  localparam int unsigned T_EN    = 25;
  localparam int unsigned T_HOLD  = 2;
  localparam int unsigned T_SHORT = 40;
  localparam int unsigned T_LONG  = 150;

  logic       clk;
  logic       reset;
  logic       start;
  logic       rs_in;
  logic [7:0] data_in;
  logic       ready;
  logic       done;
  logic       overrun;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;

  int checks = 0;
  int errors = 0;
  int rw_bad = 0;

  lcd_bus_driver #(
    .SETUP_CYC      (T_SETUP),
    .EN_HIGH_CYC    (T_EN),
    .HOLD_CYC       (T_HOLD),
    .EXEC_SHORT_CYC (T_SHORT),
    .EXEC_LONG_CYC  (T_LONG)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rs_in    (rs_in),
    .data_in  (data_in),
    .ready    (ready),
    .done     (done),
    .overrun  (overrun),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en),
    .lcd_data (lcd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (lcd_rw !== 1'b0) rw_bad++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Call at a negedge with start already driven high for the request.
  // Follows the write until done, checking pin timing along the way.
  // poke: pulse start with 0xFF during WAIT. chain: raise the next
  // request in the done cycle and return without waiting.
  task automatic watch(input string tag, input logic rs, input logic [7:0] data,
                       input int wait_len, input bit poke,
                       input bit chain, input logic crs, input logic [7:0] cdata);
    int done_n;
    int en_len;
    int en_bad;
    int dat_bad;
    int rdy_bad;
    done_n  = -1;
    en_len  = 0;
    en_bad  = 0;
    dat_bad = 0;
    rdy_bad = 0;
    @(posedge clk);  // acceptance edge
    for (int n = 0; n < 31 + wait_len + 20; n++) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
      if (lcd_en === 1'b1) en_len++;
      if (lcd_en !== ((n >= 4) && (n <= 28))) en_bad++;
      if (lcd_rs !== rs || lcd_data !== data) dat_bad++;
      if (poke && n == 40) begin
        start   = 1'b1;
        data_in = 8'hFF;
      end
      if (poke && n == 41) begin
        start   = 1'b0;
        data_in = data;
      end
      if (done === 1'b1) begin
        done_n = n;
        if (ready !== 1'b1) rdy_bad++;
        break;
      end
      if (ready !== 1'b0) rdy_bad++;
    end
    check({tag, " en_len"}, en_len, T_EN);
    check({tag, " en_window_err"}, en_bad, 0);
    check({tag, " rs_data_err"}, dat_bad, 0);
    check({tag, " ready_err"}, rdy_bad, 0);
    check({tag, " done_latency"}, done_n, 31 + wait_len);
    if (chain) begin
      start   = 1'b1;
      rs_in   = crs;
      data_in = cdata;
    end
  endtask

  task automatic write_chk(input string tag, input logic rs, input logic [7:0] data,
                           input int wait_len);
    @(negedge clk);
    start   = 1'b1;
    rs_in   = rs;
    data_in = data;
    watch(tag, rs, data, wait_len, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dcount;
    reset   = 1'b1;
    start   = 1'b1;  // must be ignored while reset is high
    rs_in   = 1'b1;
    data_in = 8'hAA;
    repeat (3) @(negedge clk);
    check("reset lcd_en", lcd_en, 0);
    check("reset ready", ready, 1);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("post_reset ready", ready, 1);
    check("post_reset lcd_en", lcd_en, 0);
    check("post_reset lcd_rs", lcd_rs, 0);
    check("post_reset lcd_data", lcd_data, 8'h00);
    check("post_reset done", done, 0);
    check("post_reset overrun", overrun, 0);

    write_chk("data_41", 1'b1, 8'h41, T_SHORT);
    write_chk("cmd_01", 1'b0, 8'h01, T_LONG);
    write_chk("cmd_02", 1'b0, 8'h02, T_LONG);
    write_chk("cmd_03", 1'b0, 8'h03, T_LONG);
    write_chk("cmd_04", 1'b0, 8'h04, T_SHORT);
    write_chk("cmd_80", 1'b0, 8'h80, T_SHORT);
    write_chk("data_01", 1'b1, 8'h01, T_SHORT);

    // Back-to-back: second request raised in the done cycle.
    @(negedge clk);
    start   = 1'b1;
    rs_in   = 1'b1;
    data_in = 8'h48;
    watch("b2b_first", 1'b1, 8'h48, T_SHORT, 1'b0, 1'b1, 1'b0, 8'h01);
    watch("b2b_second", 1'b0, 8'h01, T_LONG, 1'b0, 1'b0, 1'b0, 8'h00);
    check("b2b overrun", overrun, 0);

    // Overrun: start during WAIT is ignored but flagged.
    @(negedge clk);
    start   = 1'b1;
    rs_in   = 1'b1;
    data_in = 8'h55;
    watch("ovr", 1'b1, 8'h55, T_SHORT, 1'b1, 1'b0, 1'b0, 8'h00);
    check("ovr overrun", overrun, 1);
    dcount = 0;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    check("ovr extra_done", dcount, 0);
    check("ovr lcd_data", lcd_data, 8'h55);
    check("ovr still_set", overrun, 1);

    // Reset on the 10th enable-high cycle.
    @(negedge clk);
    start   = 1'b1;
    rs_in   = 1'b1;
    data_in = 8'h5A;
    @(posedge clk);
    for (int n = 0; n <= 13; n++) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
    end
    check("mid_en lcd_en_before", lcd_en, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_en lcd_en", lcd_en, 0);
    check("mid_en lcd_data", lcd_data, 8'h00);
    check("mid_en lcd_rs", lcd_rs, 0);
    check("mid_en ready", ready, 1);
    check("mid_en overrun", overrun, 0);
    reset = 1'b0;
    dcount = 0;
    repeat (2 * (31 + T_LONG)) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    check("mid_en no_done", dcount, 0);
    check("final ready", ready, 1);
    check("final lcd_en", lcd_en, 0);
    check("lcd_rw never_high", rw_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
